decoder_3to8: RTL and testbench

- Registered 3-to-8 line decoder with active-low outputs, functionally equivalent to a 74x138.
- Has three enable inputs: two active-low and one active-high.
- Used in the address-decode and chip-select path, so each select line drops low for exactly one address when the decoder is enabled.
- Outputs are registered on the single system clock and forced inactive (all high) by an asynchronous active-high reset.

---
 rtl/decoder_3to8.sv | 50 +++++
 tb/tb_decoder_3to8.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/decoder_3to8.sv
// Registered 3-to-8 decoder with active-low outputs and 74x138-style enables.
// Define DECODER_3TO8_COMB_OUT_EN to drop the output register (zero latency).
module decoder_3to8 (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] a,
  input  logic       e1_n,
  input  logic       e2_n,
  input  logic       e3,
  output logic [7:0] y_n
);

  logic       en;
  logic [7:0] y_next;

  assign en = ~e1_n & ~e2_n & e3;

  // An unknown enable falls to the else branch, so at most one line is ever low.
  always_comb begin
    y_next = 8'hFF;
    if (en == 1'b1) begin
      for (int i = 0; i < 8; i++) begin
        if (a == 3'(i)) begin
          y_next[i] = 1'b0;
        end
      end
    end
  end

`ifdef DECODER_3TO8_COMB_OUT_EN
  logic unused_clk;
  assign unused_clk = clk;

  always_comb begin
    y_n = y_next;
    if (rst) begin
      y_n = 8'hFF;
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_n <= 8'hFF;
    end else begin
      y_n <= y_next;
    end
  end
`endif

endmodule

// File: tb/tb_decoder_3to8.sv
// Scoreboard bench for decoder_3to8: the driver queues reference results, a monitor checks them.
module tb_decoder_3to8;

  logic       clk;
  logic       rst;
  logic [2:0] a;
  logic       e1_n;
  logic       e2_n;
  logic       e3;
  logic [7:0] y_n;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [7:0]  exp_q[$];

  decoder_3to8 dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .e1_n (e1_n),
    .e2_n (e2_n),
    .e3   (e3),
    .y_n  (y_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: selected line low only when all three enables are asserted.
  function automatic logic [7:0] ref_model(input logic [2:0] sel, input logic en1_n,
                                           input logic en2_n, input logic en3);
    if (!en1_n && !en2_n && en3) return 8'hFF ^ (8'd1 << sel);
    return 8'hFF;
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: y_n=%h expected %h at %0t", name, got, want, $time);
    end
  endtask

  // Called right after a falling edge; result is due at the next rising edge
  // (or immediately in the combinational build).
  task automatic drive(input logic [2:0] sel, input logic en1_n, input logic en2_n,
                       input logic en3);
    a    = sel;
    e1_n = en1_n;
    e2_n = en2_n;
    e3   = en3;
    exp_q.push_back(ref_model(sel, en1_n, en2_n, en3));
`ifdef DECODER_3TO8_COMB_OUT_EN
    #1;
    check("comb_zero_latency", y_n, ref_model(sel, en1_n, en2_n, en3));
`endif
  endtask

  task automatic step(input logic [2:0] sel, input logic en1_n, input logic en2_n,
                      input logic en3);
    @(negedge clk);
    drive(sel, en1_n, en2_n, en3);
  endtask

  // Monitor: every rising edge presents one result.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      check("scoreboard", y_n, exp_q.pop_front());
    end
    if (exp_q.size() > 1) begin
      n_errors++;
      $display("FAIL queue_depth: depth=%0d expected <=1", exp_q.size());
    end
    if (!rst) begin
      n_checks++;
      if ($isunknown(y_n) || $countones(~y_n) > 1) begin
        n_errors++;
        $display("FAIL one_low_invariant: y_n=%b expected at most one zero", y_n);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: run exceeded 200000 time units");
    $fatal(1, "timeout");
  end

  initial begin
    rst  = 1'b1;
    a    = 3'b010;
    e1_n = 1'b0;
    e2_n = 1'b0;
    e3   = 1'b1;
    #1;
    check("reset_async", y_n, 8'hFF);
    @(posedge clk);
    #1;
    check("reset_hold", y_n, 8'hFF);

    @(negedge clk);
    rst = 1'b0;
    drive(3'b010, 1'b0, 1'b0, 1'b1);          // FB

    step(3'b010, 1'b0, 1'b0, 1'b0);           // e3 low -> FF
    step(3'b010, 1'b0, 1'b0, 1'b1);           // FB
    step(3'b010, 1'b0, 1'b1, 1'b1);           // e2_n high -> FF
    step(3'b101, 1'b0, 1'b0, 1'b1);           // DF
    step(3'b110, 1'b0, 1'b0, 1'b1);           // BF
    step(3'b011, 1'b0, 1'b0, 1'b1);           // F7
    step(3'b000, 1'b0, 1'b0, 1'b1);           // FE
    step(3'b111, 1'b0, 1'b0, 1'b1);           // 7F
    step(3'b001, 1'b1, 1'b0, 1'b1);           // e1_n high -> FF
    step(3'b001, 1'b0, 1'b0, 1'b1);           // FD
    step(3'b001, 1'b0, 1'b0, 1'b1);           // FD held, then reset pulse between edges

    #2;
    check("pre_pulse_active", y_n, 8'hFD);
    rst = 1'b1;
    #1;
    check("reset_mid_run", y_n, 8'hFF);
    rst = 1'b0;

    for (int i = 0; i < 64; i++) begin
      logic [5:0] v;
      v = 6'(i);
      step(v[5:3], v[2], v[1], v[0]);
    end

    for (int i = 0; i < 300; i++) begin
      logic [5:0] r;
      r = 6'($urandom);
      // Bias toward enabled so the sweep exercises every select line.
      if ($urandom_range(0, 2) != 0) r[2:0] = 3'b001;
      step(r[5:3], r[2], r[1], r[0]);
    end

    @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
